// File: rtl/bias_stream_unit.sv
// bias_stream_unit: per-channel bias adder between the accumulator array and
// the layer output buffer. The bias table is sign-magnitude. Each accepted
// accumulator beat gets the bias of the current channel added. The result is
// optionally ReLU-clamped, saturated to DATA_W, and tagged with its channel.
// The pipeline is two stages (S1, S2) that share one advance enable.

module bias_stream_unit #(
    parameter int NUM_CH  = 112,
    parameter int CH_W    = $clog2(NUM_CH),
    parameter int ACC_W   = 24,
    parameter int DATA_W  = 16,
    parameter bit RELU_EN = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              relu_mode,
    input  logic              ch_clr,
    input  logic              bias_wr_en,
    input  logic [CH_W-1:0]   bias_wr_addr,
    input  logic [15:0]       bias_wr_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ACC_W-1:0]  in_acc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CH_W-1:0]   out_ch,
    output logic              out_last
);

    localparam logic [CH_W-1:0]     LAST_CH = CH_W'(NUM_CH - 1);
    localparam logic [CH_W:0]       DEPTH   = (CH_W + 1)'(NUM_CH);
    localparam logic signed [ACC_W:0] SUM_MAX =
        {{(ACC_W - DATA_W + 2){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] SUM_MIN = ~SUM_MAX;
    localparam logic [DATA_W-1:0]   OUT_MAX = {1'b0, {(DATA_W - 1){1'b1}}};
    localparam logic [DATA_W-1:0]   OUT_MIN = {1'b1, {(DATA_W - 1){1'b0}}};

    logic [15:0] bias_mem [NUM_CH];

    logic              adv;
    logic              accept;
    logic [CH_W-1:0]   beat_ch;

    logic [CH_W-1:0]   ch_q, ch_d;
    logic              s1_valid_q, s1_valid_d;
    logic [ACC_W-1:0]  s1_acc_q, s1_acc_d;
    logic [CH_W-1:0]   s1_ch_q, s1_ch_d;
    logic              s1_relu_q, s1_relu_d;
    logic [15:0]       s1_bias_q, s1_bias_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [CH_W-1:0]   out_ch_q, out_ch_d;
    logic              out_last_q, out_last_d;

    logic signed [ACC_W:0] mag;
    logic signed [ACC_W:0] bias_tc;
    logic signed [ACC_W:0] sum;
    logic [DATA_W-1:0]     result;

    // Handshake: every stage moves when the output stage is empty or drained.
    always_comb begin
        adv      = !out_valid_q || out_ready;
        in_ready = rst_n && adv;
        accept   = in_valid && in_ready;
        beat_ch  = ch_clr ? '0 : ch_q;
    end

    // Channel counter: clear takes priority; an accept in the same cycle as a
    // clear is tagged channel 0 and leaves the counter at 1.
    always_comb begin
        ch_d = ch_q;
        if (accept) begin
            ch_d = (beat_ch == LAST_CH) ? '0 : beat_ch + 1'b1;
        end else if (ch_clr) begin
            ch_d = '0;
        end
    end

    // S1 capture: the beat, its channel, its mode, and its bias table entry.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_acc_d   = s1_acc_q;
        s1_ch_d    = s1_ch_q;
        s1_relu_d  = s1_relu_q;
        s1_bias_d  = s1_bias_q;
        if (adv) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_acc_d  = in_acc;
                s1_ch_d   = beat_ch;
                s1_relu_d = relu_mode;
                s1_bias_d = bias_mem[beat_ch];
            end
        end
    end

    // Bias conversion, add, ReLU and saturation feeding the output stage.
    always_comb begin
        mag     = {{(ACC_W - 14){1'b0}}, s1_bias_q[14:0]};
        bias_tc = s1_bias_q[15] ? -mag : mag;
        sum     = {s1_acc_q[ACC_W-1], s1_acc_q} + bias_tc;
        if (s1_relu_q && sum[ACC_W]) begin
            result = '0;
        end else if (sum > SUM_MAX) begin
            result = OUT_MAX;
        end else if (sum < SUM_MIN) begin
            result = OUT_MIN;
        end else begin
            result = sum[DATA_W-1:0];
        end
    end

    // S2 / output stage: holds while stalled, loads S1 when advancing.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_last_d  = out_last_q;
        if (adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d = result;
                out_ch_d   = s1_ch_q;
                out_last_d = (s1_ch_q == LAST_CH);
            end
        end
    end

    // Pipeline and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ch_q        <= '0;
            s1_valid_q  <= 1'b0;
            s1_acc_q    <= '0;
            s1_ch_q     <= '0;
            s1_relu_q   <= RELU_EN;
            s1_bias_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_last_q  <= 1'b0;
        end else begin
            ch_q        <= ch_d;
            s1_valid_q  <= s1_valid_d;
            s1_acc_q    <= s1_acc_d;
            s1_ch_q     <= s1_ch_d;
            s1_relu_q   <= s1_relu_d;
            s1_bias_q   <= s1_bias_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_last_q  <= out_last_d;
        end
    end

    // Bias table: not reset; out-of-range addresses are dropped.
    always_ff @(posedge clk) begin
        if (bias_wr_en && ({1'b0, bias_wr_addr} < DEPTH)) begin
            bias_mem[bias_wr_addr] <= bias_wr_data;
        end
    end

    always_comb begin
        out_valid = out_valid_q;
        out_data  = out_data_q;
        out_ch    = out_ch_q;
        out_last  = out_last_q;
    end

endmodule

// File: tb/tb_bias_stream_unit.sv
// Testbench for bias_stream_unit. The stimulus side pushes the expected
// results of accepted beats into a queue. A separate monitor compares every
// presented output beat with the head of that queue.

module tb_bias_stream_unit;

    localparam int NUM_CH = 112;
    localparam int CH_W   = 7;
    localparam int ACC_W  = 24;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              relu_mode;
    logic              ch_clr;
    logic              bias_wr_en;
    logic [CH_W-1:0]   bias_wr_addr;
    logic [15:0]       bias_wr_data;
    logic              in_valid;
    logic              in_ready;
    logic [ACC_W-1:0]  in_acc;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CH_W-1:0]   out_ch;
    logic              out_last;

    always #5 clk = ~clk;

    bias_stream_unit #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W),
        .ACC_W  (ACC_W),
        .DATA_W (DATA_W),
        .RELU_EN(1'b0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .relu_mode   (relu_mode),
        .ch_clr      (ch_clr),
        .bias_wr_en  (bias_wr_en),
        .bias_wr_addr(bias_wr_addr),
        .bias_wr_data(bias_wr_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_acc      (in_acc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_ch      (out_ch),
        .out_last    (out_last)
    );

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [CH_W-1:0]   ch;
        logic              last;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [15:0] mtab [NUM_CH];
    int          mch;
    int          total = 0;
    int          bad   = 0;

    // Reference arithmetic from the bias/saturation rules, in plain integers.
    function automatic logic [DATA_W-1:0] ref_calc(input logic [ACC_W-1:0] acc,
                                                   input logic [15:0] bias,
                                                   input logic relu);
        longint a;
        longint b;
        longint s;
        longint mx;
        longint mn;
        a  = $signed(acc);
        b  = longint'(bias[14:0]);
        if (bias[15]) b = -b;
        s  = a + b;
        mx = (longint'(1) << (DATA_W - 1)) - 1;
        mn = -(mx + 1);
        if (relu && s < 0) s = 0;
        else if (s > mx) s = mx;
        else if (s < mn) s = mn;
        return DATA_W'(s);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: evaluate the handshake just before the edge, update the
    // model, and return 2 time units after the edge.
    task automatic step(output bit accepted);
        int   c;
        exp_t x;
        accepted = 1'b0;
        @(negedge clk);
        #3;
        if (!rst_n) begin
            mch = 0;
        end else if (in_valid && in_ready) begin
            accepted = 1'b1;
            c = ch_clr ? 0 : mch;
            x.data = ref_calc(in_acc, mtab[c], relu_mode);
            x.ch   = CH_W'(c);
            x.last = (c == NUM_CH - 1);
            sb.push_back(x);
            mch = (c == NUM_CH - 1) ? 0 : c + 1;
        end else if (ch_clr) begin
            mch = 0;
        end
        if (bias_wr_en && int'(bias_wr_addr) < NUM_CH) mtab[bias_wr_addr] = bias_wr_data;
        @(posedge clk);
        #2;
        if (!rst_n) sb.delete();
    endtask

    task automatic tick();
        bit a;
        step(a);
    endtask

    task automatic send(input logic [ACC_W-1:0] acc, input logic clr);
        bit a;
        int n;
        in_valid = 1'b1;
        in_acc   = acc;
        ch_clr   = clr;
        a = 1'b0;
        n = 0;
        while (!a && n < 50) begin
            step(a);
            n++;
        end
        if (!a) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got no accept expected accept within 50 cycles");
        end
        in_valid = 1'b0;
        ch_clr   = 1'b0;
    endtask

    task automatic wr(input int addr, input logic [15:0] data);
        bias_wr_en   = 1'b1;
        bias_wr_addr = CH_W'(addr);
        bias_wr_data = data;
        tick();
        bias_wr_en   = 1'b0;
    endtask

    // Monitor: every presented beat must match the oldest expected result.
    always begin
        @(negedge clk);
        #4;
        if (rst_n && out_valid) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_out: got data=0x%0h ch=%0d expected no beat", out_data, out_ch);
            end else begin
                mon_e = sb[0];
                if ({out_data, out_ch, out_last} !== mon_e) begin
                    bad++;
                    $display("FAIL out_beat: got data=0x%0h ch=%0d last=%0b expected data=0x%0h ch=%0d last=%0b",
                             out_data, out_ch, out_last, mon_e.data, mon_e.ch, mon_e.last);
                end
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit a;
        int n;
        rst_n        = 1'b0;
        relu_mode    = 1'b0;
        ch_clr       = 1'b0;
        bias_wr_en   = 1'b0;
        bias_wr_addr = '0;
        bias_wr_data = '0;
        in_valid     = 1'b0;
        in_acc       = '0;
        out_ready    = 1'b1;
        mch          = 0;

        // Reset state
        for (int i = 0; i < 3; i++) tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_ch", 32'(out_ch), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Fill the whole table so every channel has a known bias
        for (int i = 0; i < NUM_CH; i++) wr(i, 16'($urandom));
        wr(0, 16'h0010);
        wr(1, 16'h8010);

        // Basic add and 2-cycle latency
        send(ACC_W'(100), 1'b0);
        chk("lat_not_yet", 32'(out_valid), 32'd0);
        send(ACC_W'(100), 1'b0);
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("basic_ch0", 32'(out_data), 32'd116);
        chk("basic_ch0_tag", 32'(out_ch), 32'd0);
        tick();
        chk("basic_ch1", 32'(out_data), 32'd84);
        chk("basic_ch1_last", 32'(out_last), 32'd0);

        // Wrap: 113 beats from channel 0
        ch_clr = 1'b1;
        tick();
        ch_clr = 1'b0;
        for (int i = 0; i < NUM_CH + 1; i++) send(ACC_W'(0), 1'b0);
        tick();
        tick();

        // Saturation and negative zero on channel 0
        wr(0, 16'h0010);
        send(ACC_W'(32760), 1'b1);
        tick();
        chk("sat_pos", 32'(out_data), 32'h7fff);
        wr(0, 16'h8010);
        send(ACC_W'(-32760), 1'b1);
        tick();
        chk("sat_neg", 32'(out_data), 32'h8000);
        wr(0, 16'h8000);
        send(ACC_W'(5), 1'b1);
        tick();
        chk("neg_zero", 32'(out_data), 32'd5);

        // ReLU
        wr(0, 16'h0010);
        relu_mode = 1'b1;
        send(ACC_W'(-50), 1'b1);
        tick();
        chk("relu_on", 32'(out_data), 32'd0);
        relu_mode = 1'b0;
        send(ACC_W'(-50), 1'b1);
        tick();
        chk("relu_off", 32'(out_data), 32'hffde);

        // Backpressure
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_acc = ACC_W'($urandom_range(0, 4000));
            tick();
            if (i >= 1) chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_acc = ACC_W'($urandom_range(0, 4000));
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();

        // ch_clr together with an accept at counter 57
        ch_clr = 1'b1;
        tick();
        ch_clr = 1'b0;
        for (int i = 0; i < 57; i++) send(ACC_W'(i), 1'b0);
        send(ACC_W'(1), 1'b1);
        send(ACC_W'(2), 1'b0);
        chk("clr57_ch0", 32'(out_ch), 32'd0);
        tick();
        chk("clr57_ch1", 32'(out_ch), 32'd1);

        // Same-cycle write to the channel being accepted
        wr(3, 16'h0005);
        ch_clr = 1'b1;
        tick();
        ch_clr = 1'b0;
        for (int i = 0; i < 3; i++) send(ACC_W'(0), 1'b0);
        bias_wr_en   = 1'b1;
        bias_wr_addr = CH_W'(3);
        bias_wr_data = 16'h0100;
        send(ACC_W'(1000), 1'b0);
        bias_wr_en = 1'b0;
        tick();
        chk("same_cycle_old", 32'(out_data), 32'd1005);
        wr(120, 16'h7fff);
        ch_clr = 1'b1;
        tick();
        ch_clr = 1'b0;
        for (int i = 0; i < 3; i++) send(ACC_W'(0), 1'b0);
        send(ACC_W'(1000), 1'b0);
        tick();
        chk("later_new", 32'(out_data), 32'd1256);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            in_valid     = ($urandom_range(0, 99) < 70);
            in_acc       = ($urandom_range(0, 1) == 0) ? ACC_W'($urandom)
                                                       : ACC_W'(int'($urandom_range(0, 80000)) - 40000);
            ch_clr       = ($urandom_range(0, 99) < 3);
            bias_wr_en   = ($urandom_range(0, 99) < 15);
            bias_wr_addr = CH_W'($urandom_range(0, 127));
            bias_wr_data = 16'($urandom);
            relu_mode    = 1'($urandom_range(0, 1));
            out_ready    = ($urandom_range(0, 99) < 70);
            tick();
        end
        in_valid   = 1'b0;
        ch_clr     = 1'b0;
        bias_wr_en = 1'b0;
        relu_mode  = 1'b0;

        // Reset mid-stream
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_acc = ACC_W'($urandom_range(0, 500));
            tick();
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("midrst_no_partial", 32'(out_valid), 32'd0);
        send(ACC_W'(7), 1'b0);
        send(ACC_W'(7), 1'b0);
        chk("midrst_ch0", 32'(out_ch), 32'd0);

        // Drain
        out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            step(a);
            n++;
        end
        tick();
        chk("drain_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
